// File: rtl/galois_lfsr_gen.sv
// Parametrised Galois LFSR with free-run stepping, seed load and counted bursts.
// Ports: clk, rst_n (async active-low), en, load, seed_in, start, step_cnt in;
// lfsr_out, bit_out, busy, done, lock_err out. Macro: LFSR_ZERO_GUARD_EN.
module galois_lfsr_gen #(
    parameter int                 WIDTH = 16,
    parameter logic [WIDTH-1:0]   POLY  = 16'hB400,
    parameter logic [WIDTH-1:0]   SEED  = 16'hACE1,
    parameter int                 CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             start,
    input  logic [CNT_W-1:0] step_cnt,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             bit_out,
    output logic             busy,
    output logic             done,
    output logic             lock_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_step;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? POLY : '0);
    endfunction

`ifdef LFSR_ZERO_GUARD_EN
    logic lock_q, lock_d;
`endif

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        do_step = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
        lock_d  = lock_q;
`endif
        if (load) begin
            // load aborts any burst silently
            state_d = seed_in;
            fsm_d   = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (fsm_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_d = step_cnt;
                        fsm_d = (step_cnt == '0) ? S_DONE : S_RUN;
                    end else if (en) begin
                        do_step = 1'b1;
                    end
                end
                S_RUN: begin
                    do_step = 1'b1;
                    cnt_d   = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        fsm_d = S_DONE;
                    end
                end
                S_DONE: begin
                    fsm_d = S_IDLE;
                end
                default: begin
                    fsm_d = S_IDLE;
                end
            endcase
            if (do_step) begin
                state_d = galois_step(state_q);
            end
`ifdef LFSR_ZERO_GUARD_EN
            // escape the all-zero lockup; in RUN this replaces the step
            if (state_q == '0) begin
                state_d = SEED;
                lock_d  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            state_q <= SEED;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef LFSR_ZERO_GUARD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
    assign lock_err = lock_q;
`else
    assign lock_err = 1'b0;
`endif

    assign lfsr_out = state_q;
    assign bit_out  = state_q[0];
    assign busy     = (fsm_q == S_RUN);
    assign done     = (fsm_q == S_DONE);

endmodule
